// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and queue entry type for the register file
//            writeback path.
// Revision : 1.0
// ============================================================================
package wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // 'reg' is a keyword, so the destination index is called reg_idx
    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular queue of mult/div results with kill-by-register and a
//            live destination mask.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  wb_entry_t           i_push_entry,
    input  logic                i_pop,
    input  logic                i_kill_en,
    input  logic [REG_W-1:0]    i_kill_reg,
    output wb_entry_t           o_head,
    output logic                o_full,
    output logic                o_empty,
    output logic [NUM_REGS-1:0] o_live_mask
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Killing unoccupied slots is harmless: the mask is occupancy-gated
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && (r_mem[i].reg_idx == i_kill_reg)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_do_push) begin
                r_mem[r_wptr] <= i_push_entry;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, c_PTR_W'(c_PTR_W'(i) - r_rptr)} < r_count) &&
                r_mem[i].live && (r_mem[i].reg_idx != '0)) begin
                o_live_mask[r_mem[i].reg_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Merges ALU and queued mult/div results onto the single register
//            file write port, with kill, r0 suppression and starve stall.
// Revision : 1.0
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                alu_wb_valid,
    input  logic [REG_W-1:0]    alu_wb_reg,
    input  logic [DATA_W-1:0]   alu_wb_data,
    input  logic                md_valid,
    input  logic [REG_W-1:0]    md_reg,
    input  logic [DATA_W-1:0]   md_data,
    output logic                md_ready,
    output logic                ctrl_writeEnable,
    output logic [REG_W-1:0]    ctrl_writeReg,
    output logic [DATA_W-1:0]   data_writeReg,
    output logic                stall_alu,
    output logic [NUM_REGS-1:0] md_pending
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

    logic               w_alu_win;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    wb_entry_t          w_head;
    wb_entry_t          w_push_entry;

    logic               r_we;
    logic [REG_W-1:0]   r_reg;
    logic [DATA_W-1:0]  r_data;
    logic               r_stall;
    logic [c_CNT_W-1:0] r_starve;

    assign w_alu_win = alu_wb_valid && (alu_wb_reg != '0);
    assign w_pop     = !w_alu_win && !w_empty;
    assign md_ready  = !w_full;

    // A result arriving alongside a younger ALU write to the same reg is dead on arrival
    assign w_push_entry = '{live:    !(w_alu_win && (md_reg == alu_wb_reg)),
                            reg_idx: md_reg,
                            data:    md_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clock),
        .rst_n        (ctrl_reset),
        .i_push       (md_valid),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_alu_win),
        .i_kill_reg   (alu_wb_reg),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_live_mask  (md_pending)
    );

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_we     <= 1'b0;
            r_reg    <= '0;
            r_data   <= '0;
            r_stall  <= 1'b0;
            r_starve <= '0;
        end else begin
            r_we    <= 1'b0;
            r_stall <= 1'b0;
            if (w_alu_win) begin
                r_we   <= 1'b1;
                r_reg  <= alu_wb_reg;
                r_data <= alu_wb_data;
            end else if (w_pop) begin
                r_we   <= w_head.live && (w_head.reg_idx != '0);
                r_reg  <= w_head.reg_idx;
                r_data <= w_head.data;
            end

            // An ALU win during the stall cycle itself does not count as starvation
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (!r_stall) begin
                if (r_starve == c_CNT_W'(STARVE_LIMIT - 1)) begin
                    r_stall  <= 1'b1;
                    r_starve <= '0;
                end else begin
                    r_starve <= r_starve + c_CNT_W'(1);
                end
            end
        end
    end

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_reg;
    assign data_writeReg    = r_data;
    assign stall_alu        = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed bench for writeback_arbiter with a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_writeback_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    wire         md_ready;
    wire         ctrl_writeEnable;
    wire  [4:0]  ctrl_writeReg;
    wire  [31:0] data_writeReg;
    wire         stall_alu;
    wire  [31:0] md_pending;

    writeback_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_reg       (alu_wb_reg),
        .alu_wb_data      (alu_wb_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .stall_alu        (stall_alu),
        .md_pending       (md_pending)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue-level reference: program-order list of results with a live flag
    typedef struct {
        bit          live;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_we     = 1'b0;
    bit          m_stall  = 1'b0;
    logic [4:0]  m_reg    = '0;
    logic [31:0] m_data   = '0;
    int          m_starve = 0;

    function automatic logic [31:0] exp_pending();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) if (q[i].live && q[i].r != 0) m[q[i].r] = 1'b1;
        return m;
    endfunction

    always @(posedge clock or negedge ctrl_reset) begin
        bit   win, was_empty, popped, prev_stall, accept;
        ent_t e;
        if (!ctrl_reset) begin
            q.delete();
            m_we = 0; m_reg = '0; m_data = '0; m_stall = 0; m_starve = 0;
        end else begin
            win        = alu_wb_valid && (alu_wb_reg != 0);
            was_empty  = (q.size() == 0);
            accept     = md_valid && (q.size() < DEPTH);
            prev_stall = m_stall;
            popped     = 0;
            m_stall    = 0;
            m_we       = 0;
            if (win) begin
                m_we = 1; m_reg = alu_wb_reg; m_data = alu_wb_data;
                foreach (q[i]) if (q[i].r == alu_wb_reg) q[i].live = 0;
            end else if (!was_empty) begin
                e = q.pop_front();
                popped = 1;
                m_we = e.live && (e.r != 0);
                if (m_we) begin m_reg = e.r; m_data = e.d; end
            end
            if (was_empty || popped) m_starve = 0;
            else if (!prev_stall) begin
                m_starve++;
                if (m_starve == STARVE_LIMIT) begin m_stall = 1; m_starve = 0; end
            end
            if (accept)
                q.push_back('{live: !(win && md_reg == alu_wb_reg), r: md_reg, d: md_data});
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_we", {31'b0, ctrl_writeEnable}, {31'b0, m_we});
            if (m_we) begin
                chk("m_reg", {27'b0, ctrl_writeReg}, {27'b0, m_reg});
                chk("m_data", data_writeReg, m_data);
            end
            chk("m_stall", {31'b0, stall_alu}, {31'b0, m_stall});
            chk("m_ready", {31'b0, md_ready}, {31'b0, (q.size() < DEPTH)});
            chk("m_pending", md_pending, exp_pending());
        end
    end

    task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_wb_valid = v; alu_wb_reg = r; alu_wb_data = d;
    endtask

    task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
        md_valid = v; md_reg = r; md_data = d;
    endtask

    task automatic idle_state(input string tag);
        chk({tag, "_we"},   {31'b0, ctrl_writeEnable}, 32'd0);
        chk({tag, "_reg"},  {27'b0, ctrl_writeReg}, 32'd0);
        chk({tag, "_data"}, data_writeReg, 32'd0);
        chk({tag, "_stall"}, {31'b0, stall_alu}, 32'd0);
        chk({tag, "_ready"}, {31'b0, md_ready}, 32'd1);
        chk({tag, "_pend"}, md_pending, 32'd0);
    endtask

    initial begin
        ctrl_reset = 1'b0;
        alu(0, 0, 0);
        md(0, 0, 0);
        repeat (3) @(negedge clock);
        idle_state("reset");
        ctrl_reset = 1'b1;
        chk_en     = 1'b1;

        // ALU write to r5
        alu(1, 5, 32'h1234);
        @(negedge clock);
        alu(0, 0, 0);
        chk("alu_we", {31'b0, ctrl_writeEnable}, 32'd1);
        chk("alu_reg", {27'b0, ctrl_writeReg}, 32'd5);
        chk("alu_data", data_writeReg, 32'h1234);

        // ALU write to r0 is suppressed
        alu(1, 0, 32'hFFFF_FFFF);
        @(negedge clock);
        alu(0, 0, 0);
        chk("r0_we", {31'b0, ctrl_writeEnable}, 32'd0);

        // mult/div r7 through the queue
        md(1, 7, 32'hABCD);
        @(negedge clock);
        md(0, 0, 0);
        chk("md_pend7", md_pending, 32'h0000_0080);
        chk("md_we_early", {31'b0, ctrl_writeEnable}, 32'd0);
        @(negedge clock);
        chk("md_we", {31'b0, ctrl_writeEnable}, 32'd1);
        chk("md_reg", {27'b0, ctrl_writeReg}, 32'd7);
        chk("md_data", data_writeReg, 32'hABCD);
        chk("md_pend_clr", md_pending, 32'd0);

        // mult/div to r0: consumed, never pending, never written
        md(1, 0, 32'h1);
        @(negedge clock);
        md(0, 0, 0);
        chk("md0_pend", md_pending, 32'd0);
        @(negedge clock);
        chk("md0_we", {31'b0, ctrl_writeEnable}, 32'd0);
        chk("md0_ready", {31'b0, md_ready}, 32'd1);

        // Kill: queued r9 superseded by a younger ALU write to r9
        md(1, 9, 32'h9999);
        @(negedge clock);
        md(0, 0, 0);
        alu(1, 9, 32'h5555);
        chk("kill_pend9", md_pending, 32'h0000_0200);
        @(negedge clock);
        alu(0, 0, 0);
        chk("kill_alu_we", {31'b0, ctrl_writeEnable}, 32'd1);
        chk("kill_alu_reg", {27'b0, ctrl_writeReg}, 32'd9);
        chk("kill_alu_data", data_writeReg, 32'h5555);
        chk("kill_pend_clr", md_pending, 32'd0);
        @(negedge clock);
        chk("kill_pop_we", {31'b0, ctrl_writeEnable}, 32'd0);
        chk("kill_ready", {31'b0, md_ready}, 32'd1);
        @(negedge clock);
        chk("kill_after_we", {31'b0, ctrl_writeEnable}, 32'd0);

        // Fill the queue under a continuous ALU stream, then drain
        alu(1, 1, 32'h101); md(1, 10, 32'hA0);
        @(negedge clock);
        alu(1, 1, 32'h102); md(1, 11, 32'hA1);
        chk("fill_ready1", {31'b0, md_ready}, 32'd1);
        @(negedge clock);
        alu(1, 1, 32'h103); md(0, 0, 0);
        chk("fill_full", {31'b0, md_ready}, 32'd0);
        chk("fill_pend", md_pending, 32'h0000_0C00);
        @(negedge clock);
        alu(1, 1, 32'h104);
        chk("fill_stall3", {31'b0, stall_alu}, 32'd0);
        @(negedge clock);
        alu(1, 1, 32'h105);
        chk("fill_stall4", {31'b0, stall_alu}, 32'd0);
        @(negedge clock);
        alu(0, 0, 0);
        chk("fill_stall5", {31'b0, stall_alu}, 32'd1);
        chk("fill_alu_data", data_writeReg, 32'h105);
        @(negedge clock);
        chk("drain_stall", {31'b0, stall_alu}, 32'd0);
        chk("drain0_reg", {27'b0, ctrl_writeReg}, 32'd10);
        chk("drain0_data", data_writeReg, 32'hA0);
        @(negedge clock);
        chk("drain1_we", {31'b0, ctrl_writeEnable}, 32'd1);
        chk("drain1_reg", {27'b0, ctrl_writeReg}, 32'd11);
        chk("drain1_data", data_writeReg, 32'hA1);
        @(negedge clock);
        chk("drain_done_we", {31'b0, ctrl_writeEnable}, 32'd0);

        // Asynchronous reset with two entries queued
        alu(1, 2, 32'h200); md(1, 12, 32'hC0);
        @(negedge clock);
        alu(1, 2, 32'h201); md(1, 13, 32'hC1);
        @(negedge clock);
        md(0, 0, 0);
        chk("rst_full", {31'b0, md_ready}, 32'd0);
        #2 ctrl_reset = 1'b0;
        #1 idle_state("async_rst");
        alu(0, 0, 0);
        @(negedge clock);
        ctrl_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_we", {31'b0, ctrl_writeEnable}, 32'd0);
        end

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
